// File: rtl/signal_cfg_pkg.sv
// signal_cfg_pkg: field widths, bus layout and update-mode encoding shared by
// the signal-generator config shadow chain.
package signal_cfg_pkg;

    localparam int OFFSET_W = 16;
    localparam int RAMP_W   = 48;
    localparam int CFG_W    = 48;
    localparam int AMP_W    = 16;
    localparam int FREQ_W   = 48;
    localparam int PHASE_W  = 48;

    localparam int HDR_W  = 64;
    localparam int SLOT_W = 192;

    localparam int HDR_OFFSET_LSB = 0;
    localparam int HDR_RAMP_LSB   = 16;

    localparam int SLOT_CFG_LSB   = 0;
    localparam int SLOT_AMP_LSB   = 48;
    localparam int SLOT_FREQ_LSB  = 64;
    localparam int SLOT_PHASE_LSB = 128;

    // Reserved holes inside each slot; carried on the bus but never compared.
    localparam int SLOT_RSVD0_LSB = 112;
    localparam int SLOT_RSVD0_W   = 16;
    localparam int SLOT_RSVD1_LSB = 176;
    localparam int SLOT_RSVD1_W   = 16;

    typedef enum logic [1:0] {
        UPD_IMMEDIATE = 2'd0,
        UPD_SYNC      = 2'd1,
        UPD_COMMIT    = 2'd2,
        UPD_RSVD      = 2'd3
    } upd_mode_e;

    function automatic int cfg_dw(input int n);
        return HDR_W + SLOT_W * n;
    endfunction

endpackage

// File: rtl/signal_cfg_field_slice.sv
// signal_cfg_field_slice: combinational extraction of one component slot.
module signal_cfg_field_slice
    import signal_cfg_pkg::*;
(
    input  logic [SLOT_W-1:0]  slot,
    output logic [CFG_W-1:0]   cfg,
    output logic [AMP_W-1:0]   amp,
    output logic [FREQ_W-1:0]  freq,
    output logic [PHASE_W-1:0] phase
);

    logic unused_rsvd;

    assign cfg   = slot[SLOT_CFG_LSB   +: CFG_W];
    assign amp   = slot[SLOT_AMP_LSB   +: AMP_W];
    assign freq  = slot[SLOT_FREQ_LSB  +: FREQ_W];
    assign phase = slot[SLOT_PHASE_LSB +: PHASE_W];

    // Reserved bits are deliberately dropped here so they never reach a compare.
    assign unused_rsvd = ^{slot[SLOT_RSVD0_LSB +: SLOT_RSVD0_W],
                           slot[SLOT_RSVD1_LSB +: SLOT_RSVD1_W]};

endmodule

// File: rtl/signal_cfg_shadow.sv
// signal_cfg_shadow: capture -> shadow -> active register chain that hands a
// complete parameter set to the DDS in one step (immediate, sync or commit).
// Build macro SIGNAL_CFG_UPD_CNT_EN adds the upd_cnt / drop_cnt counters.
module signal_cfg_shadow
    import signal_cfg_pkg::*;
#(
    parameter int N_COMP = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [cfg_dw(N_COMP)-1:0]   cfg_data,
    input  logic                        cfg_hold,
    input  logic [1:0]                  upd_mode,
    input  logic                        sync_pulse,
    input  logic                        commit,
    output logic [OFFSET_W-1:0]         offset,
    output logic [RAMP_W-1:0]           ramp_freq,
    output logic [CFG_W*N_COMP-1:0]     comp_cfg,
    output logic [AMP_W*N_COMP-1:0]     comp_amp,
    output logic [FREQ_W*N_COMP-1:0]    comp_freq,
    output logic [PHASE_W*N_COMP-1:0]   comp_phase,
    output logic                        pending,
    output logic                        upd_pulse
`ifdef SIGNAL_CFG_UPD_CNT_EN
    ,
    output logic [15:0]                 upd_cnt,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int CFG_DW = cfg_dw(N_COMP);

    logic [CFG_DW-1:0]         cap_q;
    logic [CFG_DW-1:0]         shadow_q;
    logic [CFG_W*N_COMP-1:0]   cap_cfg,   sh_cfg;
    logic [AMP_W*N_COMP-1:0]   cap_amp,   sh_amp;
    logic [FREQ_W*N_COMP-1:0]  cap_freq,  sh_freq;
    logic [PHASE_W*N_COMP-1:0] cap_phase, sh_phase;
    logic                      shadow_load;
    logic                      trigger;
    logic                      apply;
    upd_mode_e                 mode;

    assign mode = upd_mode_e'(upd_mode);

    for (genvar k = 0; k < N_COMP; k++) begin : g_slot
        signal_cfg_field_slice u_cap (
            .slot  (cap_q[HDR_W + SLOT_W*k +: SLOT_W]),
            .cfg   (cap_cfg[CFG_W*k +: CFG_W]),
            .amp   (cap_amp[AMP_W*k +: AMP_W]),
            .freq  (cap_freq[FREQ_W*k +: FREQ_W]),
            .phase (cap_phase[PHASE_W*k +: PHASE_W])
        );
        signal_cfg_field_slice u_sh (
            .slot  (shadow_q[HDR_W + SLOT_W*k +: SLOT_W]),
            .cfg   (sh_cfg[CFG_W*k +: CFG_W]),
            .amp   (sh_amp[AMP_W*k +: AMP_W]),
            .freq  (sh_freq[FREQ_W*k +: FREQ_W]),
            .phase (sh_phase[PHASE_W*k +: PHASE_W])
        );
    end

    // Shadow reloads only when a meaningful field of the capture differs.
    assign shadow_load = (cap_q[HDR_W-1:0] != shadow_q[HDR_W-1:0]) ||
                         (cap_cfg != sh_cfg) || (cap_amp != sh_amp) ||
                         (cap_freq != sh_freq) || (cap_phase != sh_phase);

    // Trigger selection; the reserved mode behaves like SYNC.
    always_comb begin
        trigger = 1'b0;
        case (mode)
            UPD_IMMEDIATE: trigger = 1'b1;
            UPD_COMMIT:    trigger = commit;
            default:       trigger = sync_pulse;
        endcase
    end

    assign apply = pending && trigger;

    // Capture stage, frozen while the PS assembles a multi-word update.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            cap_q <= '0;
        else if (!cfg_hold)
            cap_q <= cfg_data;
    end

    // Shadow stage and pending flag; a same-cycle load keeps pending set.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            shadow_q <= '0;
            pending  <= 1'b0;
        end else begin
            if (shadow_load) begin
                shadow_q <= cap_q;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

    // Active stage: the whole set moves at once; it always takes the old shadow.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            offset     <= '0;
            ramp_freq  <= '0;
            comp_cfg   <= '0;
            comp_amp   <= '0;
            comp_freq  <= '0;
            comp_phase <= '0;
            upd_pulse  <= 1'b0;
        end else begin
            upd_pulse <= apply;
            if (apply) begin
                offset     <= shadow_q[HDR_OFFSET_LSB +: OFFSET_W];
                ramp_freq  <= shadow_q[HDR_RAMP_LSB +: RAMP_W];
                comp_cfg   <= sh_cfg;
                comp_amp   <= sh_amp;
                comp_freq  <= sh_freq;
                comp_phase <= sh_phase;
            end
        end
    end

`ifdef SIGNAL_CFG_UPD_CNT_EN
    // Applied-set counter (wraps) and overwritten-pending-set counter (saturates).
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            upd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (apply)
                upd_cnt <= upd_cnt + 16'd1;
            if (shadow_load && pending && !apply && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_signal_cfg_shadow.sv
// tb_signal_cfg_shadow: self-checking bench with a bus-level reference model.
`timescale 1ns/1ps
module tb_signal_cfg_shadow;

    localparam int N  = 4;
    localparam int DW = 64 + 192*N;
    localparam int VW = 16 + 48 + N*(48+16+48+48) + 2;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [DW-1:0]   cfg_data = '0;
    logic            cfg_hold = 1'b0;
    logic [1:0]      upd_mode = 2'd0;
    logic            sync_pulse = 1'b0;
    logic            commit = 1'b0;
    logic [15:0]     offset;
    logic [47:0]     ramp_freq;
    logic [48*N-1:0] comp_cfg;
    logic [16*N-1:0] comp_amp;
    logic [48*N-1:0] comp_freq;
    logic [48*N-1:0] comp_phase;
    logic            pending;
    logic            upd_pulse;
`ifdef SIGNAL_CFG_UPD_CNT_EN
    logic [15:0]     upd_cnt;
    logic [15:0]     drop_cnt;
`endif

    always #5 aclk = ~aclk;

    signal_cfg_shadow #(.N_COMP(N)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cfg_data   (cfg_data),
        .cfg_hold   (cfg_hold),
        .upd_mode   (upd_mode),
        .sync_pulse (sync_pulse),
        .commit     (commit),
        .offset     (offset),
        .ramp_freq  (ramp_freq),
        .comp_cfg   (comp_cfg),
        .comp_amp   (comp_amp),
        .comp_freq  (comp_freq),
        .comp_phase (comp_phase),
        .pending    (pending),
`ifdef SIGNAL_CFG_UPD_CNT_EN
        .upd_cnt    (upd_cnt),
        .drop_cnt   (drop_cnt),
`endif
        .upd_pulse  (upd_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: whole-bus snapshots with the reserved holes masked off.
    logic [DW-1:0] m_cap, m_shadow, m_active;
    logic          m_pend, m_pulse;
    logic [15:0]   m_upd, m_drop;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {offset, ramp_freq, comp_cfg, comp_amp, comp_freq, comp_phase, pending, upd_pulse};

    function automatic logic [DW-1:0] meaningful(input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = b;
        for (int k = 0; k < N; k++) begin
            r[64 + 192*k + 112 +: 16] = '0;
            r[64 + 192*k + 176 +: 16] = '0;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [48*N-1:0] c, f, p;
        logic [16*N-1:0] a;
        for (int k = 0; k < N; k++) begin
            c[48*k +: 48] = m_active[64 + 192*k       +: 48];
            a[16*k +: 16] = m_active[64 + 192*k + 48  +: 16];
            f[48*k +: 48] = m_active[64 + 192*k + 64  +: 48];
            p[48*k +: 48] = m_active[64 + 192*k + 128 +: 48];
        end
        return {m_active[15:0], m_active[63:16], c, a, f, p, m_pend, m_pulse};
    endfunction

    task automatic model_reset();
        m_cap = '0; m_shadow = '0; m_active = '0;
        m_pend = 1'b0; m_pulse = 1'b0; m_upd = '0; m_drop = '0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        logic trig, apply, load;
        if (areset) begin
            model_reset();
            return;
        end
        if (upd_mode == 2'd0)      trig = 1'b1;
        else if (upd_mode == 2'd2) trig = commit;
        else                       trig = sync_pulse;
        apply = m_pend && trig;
        load  = meaningful(m_cap) != m_shadow;
        if (load && m_pend && !apply && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (apply) begin
            m_active = m_shadow;
            m_upd    = m_upd + 16'd1;
        end
        m_pulse = apply;
        if (load) begin
            m_shadow = meaningful(m_cap);
            m_pend   = 1'b1;
        end else if (apply) begin
            m_pend = 1'b0;
        end
        if (!cfg_hold) m_cap = cfg_data;
    endtask

    task automatic tick();
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic rand_change(input bit allow_rsvd);
        int k;
        int base;
        k = $urandom_range(N-1);
        base = 64 + 192*k;
        case ($urandom_range(allow_rsvd ? 7 : 5))
            0: cfg_data[15:0]              = 16'($urandom);
            1: cfg_data[16 +: 48]          = rnd48();
            2: cfg_data[base +: 48]        = rnd48();
            3: cfg_data[base + 48 +: 16]   = 16'($urandom);
            4: cfg_data[base + 64 +: 48]   = rnd48();
            5: cfg_data[base + 128 +: 48]  = rnd48();
            6: cfg_data[base + 112 +: 16]  = 16'($urandom);
            default: cfg_data[base + 176 +: 16] = 16'($urandom);
        endcase
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", dut_vec);
        end
        tick();
        tick();
        areset = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_immediate();
        upd_mode = 2'd0;
        cfg_data[15:0] = 16'h1234;
        cfg_data[64 + 192 + 64 +: 48] = 48'h0000_1000_0000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL imm_edge%0d got %h exp %h", e, dut_vec, exp_vec());
            end
            if (e == 2) begin
                checks++;
                if (offset !== 16'h0 || upd_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL imm_early offset %h pulse %b exp 0 0", offset, upd_pulse);
                end
            end
            if (e == 3) begin
                checks++;
                if (offset !== 16'h1234 || comp_freq[95:48] !== 48'h000010000000 ||
                    upd_pulse !== 1'b1 || pending !== 1'b0) begin
                    errors++;
                    $display("FAIL imm_edge3 offset %h freq1 %h pulse %b pend %b exp 1234 000010000000 1 0",
                             offset, comp_freq[95:48], upd_pulse, pending);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cfg_data[64 + 192*(i % N) + 128 +: 48] = rnd48();
            for (int e = 0; e < 4; e++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL imm_rand got %h exp %h", dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_sync();
        upd_mode = 2'd1;
        cfg_data[64 + 48 +: 16] = 16'h7FFF;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sync_wait got %h exp %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (pending !== 1'b1 || comp_amp[15:0] === 16'h7FFF) begin
            errors++;
            $display("FAIL sync_pending pend %b amp0 %h exp 1 and not 7fff", pending, comp_amp[15:0]);
        end
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
        checks++;
        if (comp_amp[15:0] !== 16'h7FFF || upd_pulse !== 1'b1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL sync_apply amp0 %h pulse %b pend %b exp 7fff 1 0", comp_amp[15:0], upd_pulse, pending);
        end
        tick();
    endtask

    task automatic test_hold();
        int pulses;
        logic [15:0] upd0;
        upd0 = m_upd;
        upd_mode = 2'd0;
        cfg_hold = 1'b1;
        cfg_data[16 +: 16] = 16'h0002;
        tick();
        tick();
        cfg_data[32 +: 16] = 16'h0001;
        tick();
        cfg_data[48 +: 16] = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || pending !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen got %h exp %h", dut_vec, exp_vec());
            end
        end
        cfg_hold = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (upd_pulse === 1'b1) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL hold_release got %h exp %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (pulses != 1 || ramp_freq !== 48'hABCD_0001_0002) begin
            errors++;
            $display("FAIL hold_single pulses %0d ramp %h exp 1 abcd00010002", pulses, ramp_freq);
        end
`ifdef SIGNAL_CFG_UPD_CNT_EN
        checks++;
        if (upd_cnt !== 16'(upd0 + 16'd1)) begin
            errors++;
            $display("FAIL hold_upd_cnt got %h exp %h", upd_cnt, 16'(upd0 + 16'd1));
        end
`endif
    endtask

    task automatic test_commit();
        logic [47:0] v;
        v = 48'h5A5A_0000_C3C3;
        upd_mode = 2'd2;
        cfg_data[64 + 192*(N-1) + 128 +: 48] = v;
        tick(); tick(); tick();
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
        checks++;
        if (upd_pulse !== 1'b0 || pending !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL commit_ignores_sync pulse %b pend %b exp 0 1", upd_pulse, pending);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (upd_pulse !== 1'b1 || comp_phase[48*(N-1) +: 48] !== v || pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_apply pulse %b phase %h pend %b exp 1 %h 0",
                     upd_pulse, comp_phase[48*(N-1) +: 48], pending, v);
        end
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (upd_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL commit_idle pulse %b exp 0", upd_pulse);
        end
    endtask

    task automatic test_collision();
        logic [47:0] a, b, c;
        logic [15:0] drop0;
        a = 48'h0000_0000_0AAA;
        b = 48'h0000_0000_0BBB;
        c = 48'h0000_0000_0CCC;
        upd_mode = 2'd1;
        cfg_data[64 + 192*2 + 64 +: 48] = a;
        tick(); tick(); tick();
        cfg_data[64 + 192*2 + 64 +: 48] = b;
        tick();
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
        checks++;
        if (comp_freq[96 +: 48] !== a || pending !== 1'b1 || upd_pulse !== 1'b1) begin
            errors++;
            $display("FAIL collision freq2 %h pend %b pulse %b exp %h 1 1", comp_freq[96 +: 48], pending, upd_pulse, a);
        end
        drop0 = m_drop;
        cfg_data[64 + 192*2 + 64 +: 48] = c;
        tick(); tick(); tick();
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
        checks++;
        if (comp_freq[96 +: 48] !== c || pending !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL collision_next freq2 %h pend %b exp %h 0", comp_freq[96 +: 48], pending, c);
        end
`ifdef SIGNAL_CFG_UPD_CNT_EN
        checks++;
        if (drop_cnt !== 16'(drop0 + 16'd1)) begin
            errors++;
            $display("FAIL collision_drop got %h exp %h", drop_cnt, 16'(drop0 + 16'd1));
        end
`endif
    endtask

    task automatic test_reserved();
        upd_mode = 2'd0;
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            cfg_data[64 + 192*(i % N) + 112 +: 16] = 16'($urandom);
            cfg_data[64 + 192*(i % N) + 176 +: 16] = 16'($urandom);
            tick();
            checks++;
            if (pending !== 1'b0 || upd_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reserved_toggle pend %b pulse %b exp 0 0", pending, upd_pulse);
            end
        end
    endtask

    task automatic test_async_reset();
        upd_mode = 2'd1;
        cfg_data[15:0] = ~cfg_data[15:0];
        tick(); tick(); tick();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup pend %b exp 1", pending);
        end
        #2;
        areset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL areset_async got %h exp 0", dut_vec);
        end
`ifdef SIGNAL_CFG_UPD_CNT_EN
        checks++;
        if (upd_cnt !== 16'h0 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL areset_cnt upd %h drop %h exp 0 0", upd_cnt, drop_cnt);
        end
`endif
        tick();
        areset = 1'b0;
        cfg_data[15:0] = 16'hBEEF;
        for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL areset_after got %h exp %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL areset_first_pending got %b exp 1", pending);
        end
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19) == 0) upd_mode = 2'($urandom);
            cfg_hold   = ($urandom_range(4) == 0);
            sync_pulse = ($urandom_range(9) == 0);
            commit     = ($urandom_range(9) == 0);
            if ($urandom_range(2) == 0) rand_change(1'b1);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h exp %h", i, dut_vec, exp_vec());
            end
`ifdef SIGNAL_CFG_UPD_CNT_EN
            checks++;
            if (upd_cnt !== m_upd || drop_cnt !== m_drop) begin
                errors++;
                $display("FAIL random_cnt%0d upd %h drop %h exp %h %h", i, upd_cnt, drop_cnt, m_upd, m_drop);
            end
`endif
        end
        cfg_hold = 1'b0;
        sync_pulse = 1'b0;
        commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_sync();
        test_hold();
        test_commit();
        test_collision();
        test_reserved();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
